tcb_lib_arbiter_2to1: RTL and testbench
=======================================

TCB_LIB_ARBITER_2TO1 -- requirements
Module: tcb_lib_arbiter_2to1

Interface
REQ-001 Parameter ABW, default 32: address bus width.
REQ-002 Parameter DBW, default 32: data bus width.
REQ-003 Parameter SLW, default 8: byte (select) width; BEW = DBW/SLW byte-enable width.
REQ-004 Parameter DLY, default 1: subordinate response delay in cycles; legal values 0..8.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 m0_vld, m1_vld  in  1  manager request valid.
REQ-008 m0_lck, m1_lck  in  1  manager lock request (keep grant after this transfer).
REQ-009 m0_wen, m1_wen  in  1  write enable.
REQ-010 m0_adr, m1_adr  in  ABW  address.
REQ-011 m0_ben, m1_ben  in  BEW  byte enables.
REQ-012 m0_wdt, m1_wdt  in  DBW  write data.
REQ-013 m0_rdy, m1_rdy  out  1  manager ready.
REQ-014 m0_rdt, m1_rdt  out  DBW  read data.
REQ-015 m0_err, m1_err  out  1  response error.
REQ-016 s_vld, s_lck, s_wen, s_adr, s_ben, s_wdt  out  1/1/1/ABW/BEW/DBW  request to subordinate.
REQ-017 s_rdy  in  1  subordinate ready.
REQ-018 s_rdt, s_err  in  DBW/1  subordinate response, valid DLY cycles after transfer.

Function
REQ-019 Transfer on any port occurs in a cycle where vld & rdy = 1.
REQ-020 Grant: one-hot gnt[1:0]; computed combinationally from m*_vld, priority pointer ptr and lock state.
REQ-021 If lock active (lck_own valid): gnt = lck_own, regardless of the other manager's vld.
REQ-022 Else if exactly one m*_vld = 1: that manager granted.
REQ-023 Else if both valid: manager ptr granted.
REQ-024 Else gnt = 0.
REQ-025 Held request: if a granted manager has vld = 1 and s_rdy = 0, gnt is registered and held until that manager transfers; other manager cannot preempt.
REQ-026 s_* request fields = fields of granted manager; s_vld = |(m_vld & gnt); with gnt = 0, s_vld = 0 and other s_* = 0.
REQ-027 m_i_rdy = s_rdy & gnt[i]; ungranted manager sees rdy = 0.
REQ-028 Pointer update on each s transfer: ptr <= index not granted (last winner becomes lowest priority).
REQ-029 Lock: s transfer with s_lck = 1 -> lck_own <= granted index, lock active; s transfer with s_lck = 0 by lock owner -> lock released next cycle.
REQ-030 No combinational path from s_rdy to s_vld or to gnt.
REQ-031 Response routing, DLY >= 1: shift register of DLY entries {val, idx}; stage 0 loads {1, granted index} on s transfer, else {0, -}; each stage shifts every cycle; no stall.
REQ-032 Response routing, DLY = 0: routing uses current-cycle transfer {s_vld & s_rdy, granted index}.
REQ-033 At routing output stage valid with idx = i: m_i_rdt = s_rdt, m_i_err = s_err; other manager's rdt = 0, err = 0.
REQ-034 Routing output stage invalid: both m*_rdt = 0, m*_err = 0.
REQ-035 Back-to-back transfers alternating managers: full throughput, one transfer per cycle, responses routed in order.
REQ-036 Simultaneous lock release and new request from other manager: other manager granted in the same cycle the lock clears.

Reset
REQ-037 rst_n = 0 at posedge: ptr <= 0 (m0 priority), lock cleared, held grant cleared, all routing stage valids <= 0.
REQ-038 During reset: m0_rdy = m1_rdy = 0, s_vld = 0, all m*_rdt/m*_err = 0.
REQ-039 Reset asserted mid-transaction: pending responses discarded; after release, first grant follows REQ-022/023 with ptr = 0.

Verification
REQ-040 Both vld from reset, s_rdy = 1, DLY = 1 -> transfers m0, m1, m0, m1 on consecutive cycles; m0 response 1 cycle after its transfer.
REQ-041 m0 locked read (lck = 1) followed by unlocked write, m1 vld constant -> two m0 transfers, then m1 granted.
REQ-042 m1 granted, s_rdy = 0 for 3 cycles, m0 asserts vld in cycle 2 -> m1 keeps grant; m1 transfers in cycle 4; m0 next.
REQ-043 DLY = 2, m0 read adr 0x10, s_rdt = 0xDEADBEEF on response cycle -> m0_rdt = 0xDEADBEEF exactly 2 cycles after transfer; m1_rdt = 0.
REQ-044 rst_n = 0 one cycle after m1 transfer (DLY = 2) -> no response routed to m1; ptr = 0 after release.
REQ-045 DLY = 0, single m1 write, s_err = 1 -> m1_err = 1 in transfer cycle; m0_err = 0.

Source files
------------

// File: rtl/tcb_lib_arbiter_2to1_if.sv
// TCB bus bundle: one manager-to-subordinate request/response channel.
interface tcb_lib_arbiter_2to1_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8
);
  localparam int unsigned BEW = DBW / SLW;

  logic           vld;
  logic           lck;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DBW-1:0] wdt;
  logic           rdy;
  logic [DBW-1:0] rdt;
  logic           err;

  // master drives the request, slave answers with ready and response
  modport master (output vld, lck, wen, adr, ben, wdt, input  rdy, rdt, err);
  modport slave  (input  vld, lck, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_lib_arbiter_2to1.sv
// Two-manager to one-subordinate TCB arbiter.
// Round-robin between managers, with bus lock and stall hold, plus a fixed
// DLY-cycle response router that steers read data/error back to the manager
// that issued each transfer.
module tcb_lib_arbiter_2to1 #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned DLY = 1
)(
  input  logic                   clk,
  input  logic                   rst_n,
  tcb_lib_arbiter_2to1_if.slave  m0,
  tcb_lib_arbiter_2to1_if.slave  m1,
  tcb_lib_arbiter_2to1_if.master s
);
  localparam int unsigned BEW = DBW / SLW;

  logic           r_ptr;
  logic           r_lck_vld;
  logic           r_lck_idx;
  logic           r_hld_vld;
  logic           r_hld_idx;

  logic [1:0]     w_vld;
  logic [1:0]     w_gnt;
  logic           w_gidx;
  logic           w_xfr;
  logic           w_rsp_vld;
  logic           w_rsp_idx;
  logic           w_rsp_on;

  logic           w_s_vld;
  logic           w_s_lck;
  logic           w_s_wen;
  logic [ABW-1:0] w_s_adr;
  logic [BEW-1:0] w_s_ben;
  logic [DBW-1:0] w_s_wdt;

  assign w_vld = {m1.vld, m0.vld};

  // Grant: lock owner first, then a stalled holder, then round-robin.
  // Only registered state and manager valids feed this, never s.rdy.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_n) begin
      w_gnt = 2'b00;
    end else if (r_lck_vld) begin
      w_gnt = r_lck_idx ? 2'b10 : 2'b01;
    end else if (r_hld_vld) begin
      w_gnt = r_hld_idx ? 2'b10 : 2'b01;
    end else if (w_vld == 2'b11) begin
      w_gnt = r_ptr ? 2'b10 : 2'b01;
    end else begin
      w_gnt = w_vld;
    end
  end

  assign w_gidx = w_gnt[1];

  // Forward the granted manager's request; everything zero when nobody holds the bus.
  always_comb begin
    w_s_lck = 1'b0;
    w_s_wen = 1'b0;
    w_s_adr = '0;
    w_s_ben = '0;
    w_s_wdt = '0;
    if (w_gnt[0]) begin
      w_s_lck = m0.lck;
      w_s_wen = m0.wen;
      w_s_adr = m0.adr;
      w_s_ben = m0.ben;
      w_s_wdt = m0.wdt;
    end else if (w_gnt[1]) begin
      w_s_lck = m1.lck;
      w_s_wen = m1.wen;
      w_s_adr = m1.adr;
      w_s_ben = m1.ben;
      w_s_wdt = m1.wdt;
    end
  end

  assign w_s_vld = |(w_vld & w_gnt);
  assign w_xfr   = w_s_vld & s.rdy;

  assign s.vld = w_s_vld;
  assign s.lck = w_s_lck;
  assign s.wen = w_s_wen;
  assign s.adr = w_s_adr;
  assign s.ben = w_s_ben;
  assign s.wdt = w_s_wdt;

  assign m0.rdy = s.rdy & w_gnt[0];
  assign m1.rdy = s.rdy & w_gnt[1];

  // Arbitration state: priority pointer, lock ownership and stall hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= 1'b0;
      r_lck_vld <= 1'b0;
      r_lck_idx <= 1'b0;
      r_hld_vld <= 1'b0;
      r_hld_idx <= 1'b0;
    end else begin
      if (w_xfr) begin
        r_ptr <= ~w_gidx;
        if (w_s_lck) begin
          r_lck_vld <= 1'b1;
          r_lck_idx <= w_gidx;
        end else if (r_lck_vld && (r_lck_idx == w_gidx)) begin
          r_lck_vld <= 1'b0;
        end
      end
      // a stalled request keeps its grant until it finally transfers
      r_hld_vld <= w_s_vld & ~s.rdy;
      r_hld_idx <= w_gidx;
    end
  end

  generate
    if (DLY == 0) begin : g_rsp_now
      assign w_rsp_vld = w_xfr;
      assign w_rsp_idx = w_gidx;
    end else begin : g_rsp_pipe
      logic [DLY-1:0] r_rsp_vld;
      logic [DLY-1:0] r_rsp_idx;

      // Response tracker: one {valid, owner} entry per outstanding cycle, never stalls.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rsp_vld <= '0;
          r_rsp_idx <= '0;
        end else begin
          r_rsp_vld[0] <= w_xfr;
          r_rsp_idx[0] <= w_gidx;
          for (int k = 1; k < int'(DLY); k++) begin
            r_rsp_vld[k] <= r_rsp_vld[k-1];
            r_rsp_idx[k] <= r_rsp_idx[k-1];
          end
        end
      end

      assign w_rsp_vld = r_rsp_vld[DLY-1];
      assign w_rsp_idx = r_rsp_idx[DLY-1];
    end
  endgenerate

  assign w_rsp_on = rst_n & w_rsp_vld;

  assign m0.rdt = (w_rsp_on & ~w_rsp_idx) ? s.rdt : '0;
  assign m0.err = w_rsp_on & ~w_rsp_idx & s.err;
  assign m1.rdt = (w_rsp_on &  w_rsp_idx) ? s.rdt : '0;
  assign m1.err = w_rsp_on &  w_rsp_idx & s.err;

endmodule

// File: tb/tb_tcb_lib_arbiter_2to1.sv
// Bench for tcb_lib_arbiter_2to1: three instances (DLY = 0, 1, 2) share one
// manager/subordinate stimulus and are compared every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_tcb_lib_arbiter_2to1;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]        m_vld, m_lck, m_wen;
  logic [1:0][31:0]  m_adr, m_wdt;
  logic [1:0][3:0]   m_ben;
  logic              s_rdy, s_err;
  logic [31:0]       s_rdt;

  logic [ND-1:0][1:0]       o_rdy, o_err;
  logic [ND-1:0][1:0][31:0] o_rdt;
  logic [ND-1:0]            o_svld, o_slck, o_swen;
  logic [ND-1:0][31:0]      o_sadr, o_swdt;
  logic [ND-1:0][3:0]       o_sben;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int md_ptr = 0;
  int md_lck = -1;
  int md_hld = -1;
  int md_hist [8] = '{default: -1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    tcb_lib_arbiter_2to1_if #(.ABW(32), .DBW(32), .SLW(8)) if_m0 ();
    tcb_lib_arbiter_2to1_if #(.ABW(32), .DBW(32), .SLW(8)) if_m1 ();
    tcb_lib_arbiter_2to1_if #(.ABW(32), .DBW(32), .SLW(8)) if_s ();

    assign if_m0.vld = m_vld[0];
    assign if_m0.lck = m_lck[0];
    assign if_m0.wen = m_wen[0];
    assign if_m0.adr = m_adr[0];
    assign if_m0.ben = m_ben[0];
    assign if_m0.wdt = m_wdt[0];
    assign if_m1.vld = m_vld[1];
    assign if_m1.lck = m_lck[1];
    assign if_m1.wen = m_wen[1];
    assign if_m1.adr = m_adr[1];
    assign if_m1.ben = m_ben[1];
    assign if_m1.wdt = m_wdt[1];
    assign if_s.rdy  = s_rdy;
    assign if_s.rdt  = s_rdt;
    assign if_s.err  = s_err;

    tcb_lib_arbiter_2to1 #(.ABW(32), .DBW(32), .SLW(8), .DLY(g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (if_m0),
      .m1    (if_m1),
      .s     (if_s)
    );

    assign o_rdy[g][0] = if_m0.rdy;
    assign o_rdy[g][1] = if_m1.rdy;
    assign o_rdt[g][0] = if_m0.rdt;
    assign o_rdt[g][1] = if_m1.rdt;
    assign o_err[g][0] = if_m0.err;
    assign o_err[g][1] = if_m1.err;
    assign o_svld[g]   = if_s.vld;
    assign o_slck[g]   = if_s.lck;
    assign o_swen[g]   = if_s.wen;
    assign o_sadr[g]   = if_s.adr;
    assign o_sben[g]   = if_s.ben;
    assign o_swdt[g]   = if_s.wdt;
  end

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s dly%0d actual %0h required %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference: decide the winner from the arbitration rules, then compare all instances.
  always @(negedge clk) begin : p_cmp
    int          g;
    int          rt;
    logic        esv;
    logic        xfr;
    logic [127:0] ereq;
    logic [127:0] areq;

    if (!rst_n)                g = -1;
    else if (md_lck >= 0)      g = md_lck;
    else if (md_hld >= 0)      g = md_hld;
    else if (m_vld == 2'b11)   g = md_ptr;
    else if (m_vld == 2'b01)   g = 0;
    else if (m_vld == 2'b10)   g = 1;
    else                       g = -1;

    esv  = (g >= 0) ? m_vld[g] : 1'b0;
    ereq = (g >= 0) ? 128'({m_lck[g], m_wen[g], m_adr[g], m_ben[g], m_wdt[g]}) : 128'(0);
    xfr  = esv & s_rdy;

    for (int d = 0; d < ND; d++) begin
      if (!rst_n)      rt = -1;
      else if (d == 0) rt = xfr ? g : -1;
      else             rt = md_hist[d-1];
      chk("s_vld", d, 128'(o_svld[d]), 128'(esv));
      areq = 128'({o_slck[d], o_swen[d], o_sadr[d], o_sben[d], o_swdt[d]});
      chk("s_req", d, areq, ereq);
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "m0_rdy" : "m1_rdy", d, 128'(o_rdy[d][i]), 128'(s_rdy && (g == i)));
        chk(i == 0 ? "m0_rdt" : "m1_rdt", d, 128'(o_rdt[d][i]), (rt == i) ? 128'(s_rdt) : 128'(0));
        chk(i == 0 ? "m0_err" : "m1_err", d, 128'(o_err[d][i]), (rt == i) ? 128'(s_err) : 128'(0));
      end
    end

    // state as it will be after the coming posedge
    if (!rst_n) begin
      md_ptr = 0;
      md_lck = -1;
      md_hld = -1;
      for (int k = 0; k < 8; k++) md_hist[k] = -1;
    end else begin
      if (xfr) begin
        md_ptr = 1 - g;
        if (m_lck[g])         md_lck = g;
        else if (md_lck == g) md_lck = -1;
      end
      md_hld = (esv && !s_rdy) ? g : -1;
      for (int k = 7; k > 0; k--) md_hist[k] = md_hist[k-1];
      md_hist[0] = xfr ? g : -1;
    end
  end

  task automatic set_m(input int i, input logic v, input logic l, input logic w,
                       input logic [31:0] a, input logic [31:0] dt);
    m_vld[i] = v;
    m_lck[i] = l;
    m_wen[i] = w;
    m_adr[i] = a;
    m_ben[i] = 4'hF;
    m_wdt[i] = dt;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin : p_stim
    logic [1:0] keep;
    rst_n = 1'b0;
    m_vld = '0; m_lck = '0; m_wen = '0;
    m_adr = '0; m_wdt = '0; m_ben = '0;
    s_rdy = 1'b0; s_rdt = '0; s_err = 1'b0;
    nxt();
    nxt();

    // both managers requesting while reset is held
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    s_rdy = 1'b1;
    smp();
    chk("rst_m0_rdy", 1, 128'(o_rdy[1][0]), 128'(0));
    chk("rst_s_vld",  1, 128'(o_svld[1]),   128'(0));
    nxt();
    rst_n = 1'b1;

    // alternating m0, m1, m0, m1 at full rate; DLY=1 response one cycle later
    for (int k = 0; k < 4; k++) begin
      s_rdt = 32'hA000_0000 + 32'(k);
      smp();
      chk("alt_rdy", 1, 128'(o_rdy[1][k%2]), 128'(1));
      chk("alt_adr", 1, 128'(o_sadr[1]), (k % 2 == 1) ? 128'(32'h200) : 128'(32'h100));
      if (k > 0) chk("alt_rsp", 1, 128'(o_rdt[1][(k-1)%2]), 128'(32'hA000_0000 + 32'(k)));
      nxt();
    end

    // m0 locked read, then unlocked write, m1 always requesting
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    smp();
    chk("lck_first", 1, 128'(o_rdy[1][0]), 128'(1));
    chk("lck_s_lck", 1, 128'(o_slck[1]),   128'(1));
    nxt();
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h304, 32'h55);
    smp();
    chk("lck_keep",  1, 128'(o_rdy[1][0]), 128'(1));
    chk("lck_s_wen", 1, 128'(o_swen[1]),   128'(1));
    nxt();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h308, 32'h0);
    smp();
    chk("lck_rel_m1", 1, 128'(o_rdy[1][1]), 128'(1));
    chk("lck_rel_m0", 1, 128'(o_rdy[1][0]), 128'(0));
    nxt();

    // m1 stalled for three cycles, m0 joins in the second
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h77);
    s_rdy = 1'b0;
    smp();
    chk("hld_c1_vld", 1, 128'(o_svld[1]), 128'(1));
    chk("hld_c1_adr", 1, 128'(o_sadr[1]), 128'(32'h400));
    nxt();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    smp();
    chk("hld_c2_adr", 1, 128'(o_sadr[1]),   128'(32'h400));
    chk("hld_c2_m0",  1, 128'(o_rdy[1][0]), 128'(0));
    nxt();
    smp();
    chk("hld_c3_adr", 1, 128'(o_sadr[1]), 128'(32'h400));
    nxt();
    s_rdy = 1'b1;
    smp();
    chk("hld_c4_m1", 1, 128'(o_rdy[1][1]), 128'(1));
    nxt();
    smp();
    chk("hld_c5_m0", 1, 128'(o_rdy[1][0]), 128'(1));
    nxt();

    // idle so pipelines drain
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) nxt();

    // DLY=2 read response lands exactly two cycles after the transfer
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    smp();
    chk("d2_xfr", 2, 128'(o_rdy[2][0]), 128'(1));
    nxt();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rdt = 32'h1111_1111;
    smp();
    chk("d2_early", 2, 128'(o_rdt[2][0]), 128'(0));
    nxt();
    s_rdt = 32'hDEAD_BEEF;
    smp();
    chk("d2_rdt",   2, 128'(o_rdt[2][0]), 128'(32'hDEAD_BEEF));
    chk("d2_other", 2, 128'(o_rdt[2][1]), 128'(0));
    nxt();

    // DLY=0 error routed in the transfer cycle
    set_m(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h99);
    s_err = 1'b1;
    smp();
    chk("d0_m1_err", 0, 128'(o_err[0][1]), 128'(1));
    chk("d0_m0_err", 0, 128'(o_err[0][0]), 128'(0));
    nxt();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_err = 1'b0;
    repeat (3) nxt();

    // reset right after an m1 transfer discards its pending DLY=2 response
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    smp();
    chk("r_m1_xfr", 2, 128'(o_rdy[2][1]), 128'(1));
    nxt();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    s_rdt = 32'hCAFE_F00D;
    s_err = 1'b1;
    smp();
    chk("r_in_rst_rdt", 2, 128'(o_rdt[2][1]), 128'(0));
    nxt();
    rst_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    smp();
    chk("r_drop_rdt", 2, 128'(o_rdt[2][1]), 128'(0));
    chk("r_drop_err", 2, 128'(o_err[2][1]), 128'(0));
    chk("r_ptr0",     1, 128'(o_rdy[1][0]), 128'(1));
    nxt();
    s_err = 1'b0;

    // randomized traffic; a stalled request stays stable until accepted
    for (int c = 0; c < 3000; c++) begin
      smp();
      keep[0] = m_vld[0] & ~o_rdy[1][0];
      keep[1] = m_vld[1] & ~o_rdy[1][1];
      nxt();
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!keep[i]) begin
          m_vld[i] = ($urandom_range(0, 2) != 0);
          m_lck[i] = ($urandom_range(0, 3) == 0);
          m_wen[i] = 1'($urandom_range(0, 1));
          m_adr[i] = $urandom;
          m_ben[i] = 4'($urandom);
          m_wdt[i] = $urandom;
        end
      end
      s_rdy = ($urandom_range(0, 3) != 0);
      s_rdt = $urandom;
      s_err = 1'($urandom_range(0, 1));
    end

    smp();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
